// File: rtl/pkg_mips.sv
// Shared MIPS datapath types and constants used by the operand stage and ula32.
package pkg_mips;

    localparam int W    = 32;
    localparam int NREG = 32;

    typedef logic [2:0] ula_op_t;
    typedef logic [4:0] reg_idx_t;

    localparam ula_op_t ULA_OP_BUBBLE  = 3'b000;
    localparam logic    ADDSUB_BUBBLE  = 1'b0;
    localparam reg_idx_t REG_ZERO      = 5'd0;

    // True when a producer stage is writing the register being read.
    function automatic logic fwd_hit(input logic we, input reg_idx_t rd, input reg_idx_t idx);
        return we & (rd == idx);
    endfunction

endpackage

// File: rtl/banco_registradores.sv
// NREG x W register file: one write port, two combinational read ports, r0 hardwired to zero.
module banco_registradores #(
    parameter int W    = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_we,
    input  logic [4:0]   i_wa,
    input  logic [W-1:0] i_wd,
    input  logic [4:0]   i_ra1,
    input  logic [4:0]   i_ra2,
    output logic [W-1:0] o_rd1,
    output logic [W-1:0] o_rd2
);
    import pkg_mips::*;

    logic [W-1:0] r_regs [NREG];

    // Storage update: clear on reset, r0 writes dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {W{1'b0}};
            end
        end else if (i_we && (i_wa != REG_ZERO)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports; r0 forced to zero regardless of storage contents.
    always_comb begin
        o_rd1 = {W{1'b0}};
        o_rd2 = {W{1'b0}};
        if (i_ra1 != REG_ZERO) begin
            o_rd1 = r_regs[i_ra1];
        end else begin
            o_rd1 = {W{1'b0}};
        end
        if (i_ra2 != REG_ZERO) begin
            o_rd2 = r_regs[i_ra2];
        end else begin
            o_rd2 = {W{1'b0}};
        end
    end

endmodule

// File: rtl/estagio_id_ex.sv
// ID/EX operand stage: register file, operand forwarding and the ID/EX pipeline register.
// Define FORWARD_EN to enable EX/MEM forwarding; otherwise only WB write-through is used.
module estagio_id_ex #(
    parameter int W    = pkg_mips::W,
    parameter int NREG = pkg_mips::NREG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         validIn,
    input  logic [4:0]   rs,
    input  logic [4:0]   rt,
    input  logic [15:0]  imm,
    input  logic         useImm,
    input  logic [2:0]   ULAcontroleIn,
    input  logic         addSubIn,
    input  logic         weMEM,
    input  logic [4:0]   rdMEM,
    input  logic [W-1:0] dadoMEM,
    input  logic         weWB,
    input  logic [4:0]   rdWB,
    input  logic [W-1:0] dadoWB,
    output logic [W-1:0] SrcA,
    output logic [W-1:0] SrcB,
    output logic [W-1:0] rtDado,
    output logic [2:0]   ULAcontrole,
    output logic         addSub,
    output logic         validEX
);
    import pkg_mips::*;

    logic [W-1:0] w_rf_a;
    logic [W-1:0] w_rf_b;
    logic [W-1:0] w_a_res;
    logic [W-1:0] w_b_res;
    logic [W-1:0] w_imm_ext;
    logic [W-1:0] w_srcb;

    logic [W-1:0] r_srca;
    logic [W-1:0] r_srcb;
    logic [W-1:0] r_rtdado;
    ula_op_t      r_op;
    logic         r_addsub;
    logic         r_valid;

    banco_registradores #(.W(W), .NREG(NREG)) u_banco (
        .clk   (clk),
        .reset (reset),
        .i_we  (weWB),
        .i_wa  (rdWB),
        .i_wd  (dadoWB),
        .i_ra1 (rs),
        .i_ra2 (rt),
        .o_rd1 (w_rf_a),
        .o_rd2 (w_rf_b)
    );

`ifndef FORWARD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, weMEM, rdMEM, dadoMEM};
`endif

    // Operand A resolution: zero, then youngest producer, then register file.
    always_comb begin
        w_a_res = w_rf_a;
        if (rs == REG_ZERO) begin
            w_a_res = {W{1'b0}};
`ifdef FORWARD_EN
        end else if (fwd_hit(weMEM, rdMEM, rs)) begin
            w_a_res = dadoMEM;
`endif
        end else if (fwd_hit(weWB, rdWB, rs)) begin
            w_a_res = dadoWB;
        end else begin
            w_a_res = w_rf_a;
        end
    end

    // Operand rt resolution, same ordering as operand A.
    always_comb begin
        w_b_res = w_rf_b;
        if (rt == REG_ZERO) begin
            w_b_res = {W{1'b0}};
`ifdef FORWARD_EN
        end else if (fwd_hit(weMEM, rdMEM, rt)) begin
            w_b_res = dadoMEM;
`endif
        end else if (fwd_hit(weWB, rdWB, rt)) begin
            w_b_res = dadoWB;
        end else begin
            w_b_res = w_rf_b;
        end
    end

    assign w_imm_ext = {{(W-16){imm[15]}}, imm};
    assign w_srcb    = useImm ? w_imm_ext : w_b_res;

    // ID/EX register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_srca   <= {W{1'b0}};
            r_srcb   <= {W{1'b0}};
            r_rtdado <= {W{1'b0}};
            r_op     <= ULA_OP_BUBBLE;
            r_addsub <= ADDSUB_BUBBLE;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_srca   <= w_a_res;
            r_srcb   <= w_srcb;
            r_rtdado <= w_b_res;
            r_op     <= ULAcontroleIn;
            r_addsub <= addSubIn;
            r_valid  <= validIn;
        end
    end

    assign SrcA        = r_srca;
    assign SrcB        = r_srcb;
    assign rtDado      = r_rtdado;
    assign ULAcontrole = r_op;
    assign addSub      = r_addsub;
    assign validEX     = r_valid;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Self-checking bench for estagio_id_ex: directed vector table plus randomized run against a reference model.
module tb_estagio_id_ex;

    logic        clk = 1'b0;
    logic        reset, stall, flush, validIn, useImm, addSubIn, weMEM, weWB;
    logic [4:0]  rs, rt, rdMEM, rdWB;
    logic [15:0] imm;
    logic [2:0]  ULAcontroleIn;
    logic [31:0] dadoMEM, dadoWB;
    logic [31:0] SrcA, SrcB, rtDado;
    logic [2:0]  ULAcontrole;
    logic        addSub, validEX;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    estagio_id_ex dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .validIn(validIn),
        .rs(rs), .rt(rt), .imm(imm), .useImm(useImm),
        .ULAcontroleIn(ULAcontroleIn), .addSubIn(addSubIn),
        .weMEM(weMEM), .rdMEM(rdMEM), .dadoMEM(dadoMEM),
        .weWB(weWB), .rdWB(rdWB), .dadoWB(dadoWB),
        .SrcA(SrcA), .SrcB(SrcB), .rtDado(rtDado),
        .ULAcontrole(ULAcontrole), .addSub(addSub), .validEX(validEX)
    );

    typedef struct {
        logic        reset, stall, flush, valid_in, use_imm, addsub_in, we_mem, we_wb;
        logic [4:0]  rs, rt, rd_mem, rd_wb;
        logic [15:0] imm;
        logic [2:0]  op_in;
        logic [31:0] d_mem, d_wb;
        logic [31:0] e_srca, e_srcb, e_rtdado;
        logic [2:0]  e_op;
        logic        e_addsub, e_valid;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    // reference model state
    logic [31:0] mrf [32];
    logic [31:0] m_srca, m_srcb, m_rtdado;
    logic [2:0]  m_op;
    logic        m_addsub, m_valid;

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.reset; stall = v.stall; flush = v.flush; validIn = v.valid_in;
        useImm = v.use_imm; addSubIn = v.addsub_in; weMEM = v.we_mem; weWB = v.we_wb;
        rs = v.rs; rt = v.rt; rdMEM = v.rd_mem; rdWB = v.rd_wb; imm = v.imm;
        ULAcontroleIn = v.op_in; dadoMEM = v.d_mem; dadoWB = v.d_wb;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef FORWARD_EN
        if (weMEM && rdMEM == idx) return dadoMEM;
`endif
        return mrf[idx];
    endfunction

    // Model of one clock edge: the WB write lands first, so a same-cycle read sees it.
    task automatic model_edge();
        logic [31:0] a, b;
        if (reset) begin
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
            m_srca = 32'd0; m_srcb = 32'd0; m_rtdado = 32'd0;
            m_op = 3'd0; m_addsub = 1'b0; m_valid = 1'b0;
        end else begin
            if (weWB && rdWB != 5'd0) mrf[rdWB] = dadoWB;
            a = m_read(rs);
            b = m_read(rt);
            if (flush) begin
                m_srca = 32'd0; m_srcb = 32'd0; m_rtdado = 32'd0;
                m_op = 3'd0; m_addsub = 1'b0; m_valid = 1'b0;
            end else if (!stall) begin
                m_srca = a;
                m_srcb = useImm ? {{16{imm[15]}}, imm} : b;
                m_rtdado = b;
                m_op = ULAcontroleIn; m_addsub = addSubIn; m_valid = validIn;
            end
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] fwd_exp;
`ifdef FORWARD_EN
        fwd_exp = 32'd11;
`else
        fwd_exp = 32'd22;
`endif
        v = blank(); v.reset = 1'b1;                                             vecs[0] = v;
        v = blank(); v.we_wb = 1'b1; v.rd_wb = 5'd5; v.d_wb = 32'h0000_00AA;
        v.valid_in = 1'b1; v.op_in = 3'b001; v.e_op = 3'b001; v.e_valid = 1'b1;  vecs[1] = v;
        v = blank(); v.rs = 5'd5; v.valid_in = 1'b1; v.op_in = 3'b001;
        v.e_srca = 32'h0000_00AA; v.e_op = 3'b001; v.e_valid = 1'b1;             vecs[2] = v;
        v = blank(); v.we_wb = 1'b1; v.rd_wb = 5'd0; v.d_wb = 32'hFFFF_FFFF;
        v.we_mem = 1'b1; v.rd_mem = 5'd0; v.d_mem = 32'd7;                       vecs[3] = v;
        v = blank();                                                             vecs[4] = v;
        v = blank(); v.we_wb = 1'b1; v.rd_wb = 5'd4; v.d_wb = 32'd9;             vecs[5] = v;
        v = blank(); v.we_mem = 1'b1; v.rd_mem = 5'd3; v.d_mem = 32'd11;
        v.we_wb = 1'b1; v.rd_wb = 5'd3; v.d_wb = 32'd22; v.rt = 5'd3;
        v.e_srcb = fwd_exp; v.e_rtdado = fwd_exp;                                vecs[6] = v;
        v = blank(); v.imm = 16'h8001; v.use_imm = 1'b1; v.rt = 5'd4;
        v.e_srcb = 32'hFFFF_8001; v.e_rtdado = 32'd9;                            vecs[7] = v;
        v = blank(); v.op_in = 3'b010; v.valid_in = 1'b1; v.addsub_in = 1'b1;
        v.rs = 5'd5; v.rt = 5'd3;
        v.e_srca = 32'h0000_00AA; v.e_srcb = 32'd22; v.e_rtdado = 32'd22;
        v.e_op = 3'b010; v.e_addsub = 1'b1; v.e_valid = 1'b1;                    vecs[8] = v;
        v.stall = 1'b1; v.rs = 5'd4; v.op_in = 3'b111; v.valid_in = 1'b0;
        v.addsub_in = 1'b0;                                                      vecs[9] = v;
        v.we_wb = 1'b1; v.rd_wb = 5'd7; v.d_wb = 32'h0000_0077;                  vecs[10] = v;
        v = blank(); v.stall = 1'b1; v.flush = 1'b1; v.valid_in = 1'b1; v.op_in = 3'b110;
        v.rs = 5'd5;                                                             vecs[11] = v;
        v = blank(); v.rs = 5'd7; v.rt = 5'd4; v.op_in = 3'b011; v.valid_in = 1'b1;
        v.e_srca = 32'h0000_0077; v.e_srcb = 32'd9; v.e_rtdado = 32'd9;
        v.e_op = 3'b011; v.e_valid = 1'b1;                                       vecs[12] = v;
        v = blank(); v.reset = 1'b1; v.stall = 1'b1; v.we_wb = 1'b1; v.rd_wb = 5'd7;
        v.d_wb = 32'h0000_0055; v.rs = 5'd7; v.valid_in = 1'b1; v.op_in = 3'b101; vecs[13] = v;
        v = blank(); v.rs = 5'd7; v.valid_in = 1'b1; v.op_in = 3'b001;
        v.e_op = 3'b001; v.e_valid = 1'b1;                                       vecs[14] = v;

        drive(blank());
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.SrcA", i), SrcA, vecs[i].e_srca);
            chk($sformatf("vec%0d.SrcB", i), SrcB, vecs[i].e_srcb);
            chk($sformatf("vec%0d.rtDado", i), rtDado, vecs[i].e_rtdado);
            chk($sformatf("vec%0d.ULAcontrole", i), {29'd0, ULAcontrole}, {29'd0, vecs[i].e_op});
            chk($sformatf("vec%0d.addSub", i), {31'd0, addSub}, {31'd0, vecs[i].e_addsub});
            chk($sformatf("vec%0d.validEX", i), {31'd0, validEX}, {31'd0, vecs[i].e_valid});
        end

        // randomized run, starting from a reset so the model and DUT agree
        for (int c = 0; c < 500; c++) begin
            reset    = (c == 0) || ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            validIn  = 1'($urandom);
            useImm   = ($urandom_range(0, 3) == 0);
            addSubIn = 1'($urandom);
            weMEM    = 1'($urandom);
            weWB     = ($urandom_range(0, 3) != 0);
            rs       = 5'($urandom_range(0, 7));
            rt       = 5'($urandom_range(0, 7));
            rdMEM    = 5'($urandom_range(0, 7));
            rdWB     = 5'($urandom_range(0, 7));
            imm      = 16'($urandom);
            ULAcontroleIn = 3'($urandom);
            dadoMEM  = $urandom;
            dadoWB   = $urandom;
            model_edge();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.SrcA", c), SrcA, m_srca);
            chk($sformatf("rnd%0d.SrcB", c), SrcB, m_srcb);
            chk($sformatf("rnd%0d.rtDado", c), rtDado, m_rtdado);
            chk($sformatf("rnd%0d.ULAcontrole", c), {29'd0, ULAcontrole}, {29'd0, m_op});
            chk($sformatf("rnd%0d.addSub", c), {31'd0, addSub}, {31'd0, m_addsub});
            chk($sformatf("rnd%0d.validEX", c), {31'd0, validEX}, {31'd0, m_valid});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
